ahb_slave_adapter_ws: RTL and testbench
=======================================

Name: ahb_slave_adapter_ws

Overview:
AHB-Lite slave to native register-bus bridge with variable-latency handshake (reg_req/reg_ack), wait-state insertion and full two-cycle ERROR response. Generalised to 32/64/128-bit data, with size/alignment checking and a watchdog timeout on the native side. Sits between the AHB interconnect and any peripheral register file or memory-like target needing more than zero-wait access.

Parameters:
ADDR_WIDTH, 32, AHB/native address width
DATA_WIDTH, 32, data width; legal 32, 64, 128; NBYTES=DATA_WIDTH/8, OFFW=$clog2(NBYTES)
TIMEOUT_CYCLES, 256, max ACCESS cycles awaiting reg_ack before ERROR; 0 disables timeout
ERR_ON_UNALIGNED, 1, 1: unaligned transfer -> ERROR without native request; 0: issued with shifted byte enables

Ports:
hclk  in  1  clock
hresetn  in  1  reset
hsel  in  1  slave select
haddr  in  ADDR_WIDTH  address-phase address
htrans  in  2  transfer type; NONSEQ/SEQ (htrans[1]=1) are active
hwrite  in  1  1=write
hsize  in  3  transfer size, log2 bytes
hburst  in  3  ignored (each beat independent)
hprot  in  4  ignored
hwdata  in  DATA_WIDTH  data-phase write data
hready_i  in  1  bus-wide HREADY
hready_o  out  1  slave HREADYOUT
hresp  out  1  0=OKAY, 1=ERROR
hrdata  out  DATA_WIDTH  read data
reg_req  out  1  native request, held until reg_ack
reg_addr  out  ADDR_WIDTH  native address
reg_we  out  1  1=write, 0=read; valid while reg_req
reg_be  out  NBYTES  byte enables
reg_wdata  out  DATA_WIDTH  write data
reg_rdata  in  DATA_WIDTH  read data, sampled with reg_ack
reg_ack  in  1  single-cycle completion
reg_err  in  1  target error, valid with reg_ack

Behaviour:
- Reset: hresetn asynchronous, active-low; clock hclk. Async reset forces IDLE immediately from any state. Reset values: hready_o=1, hresp=0, hrdata=0, reg_req=0, reg_we=0, reg_be=0, reg_addr=0, reg_wdata=0.
- Capture: hsel && hready_i && htrans[1] registers haddr, hwrite, hsize. Capture is possible in IDLE, ERR2, and the ACCESS cycle where hready_o=1. IDLE/BUSY transfers or hsel=0 -> no capture; next state IDLE.
- Decode at capture: legal = (hsize <= OFFW) && (aligned || !ERR_ON_UNALIGNED); aligned = haddr[hsize-1:0]==0. Legal -> ACCESS; illegal -> ERR1.
- Byte enables: be = ((1<<(1<<size))-1) << addr[OFFW-1:0], truncated to NBYTES.
- States:
  - IDLE: hready_o=1, hresp=0, reg_req=0.
  - ACCESS: reg_req=1; reg_addr/reg_we/reg_be from capture regs. reg_wdata=hwdata, combinational; the master holds it stable through waits. hready_o = reg_ack && !reg_err; hresp=0. On a read, hrdata=reg_rdata; otherwise hrdata=0.
    - ack && !err: complete OKAY; next state per capture rule (ACCESS, ERR1 or IDLE).
    - ack && err: next ERR1, reg_req drops.
    - No ack: timeout counter increments. If TIMEOUT_CYCLES != 0 and the counter reaches TIMEOUT_CYCLES with no ack, next ERR1. An ack in cycle TIMEOUT_CYCLES still completes normally.
  - ERR1: hready_o=0, hresp=1, reg_req=0. Next ERR2.
  - ERR2: hready_o=1, hresp=1, reg_req=0. Capture rule applies; else IDLE.
- Latency: an ack in the first ACCESS cycle gives zero wait states. N cycles of ack delay add N wait states.
- Back-to-back: reg_req stays high across transfers. The target treats each req&&ack cycle as one completion; address/be change the cycle after ack.
- Timeout counter clears on every entry to ACCESS. A late reg_ack arriving outside ACCESS is ignored.
- hresp, hready_o and reg_req are state-decoded, except the hready_o ack path. The target's reg_ack must not combinationally depend on hready_o.

Decomposition:
- ahb_pkg:
  - HTRANS_IDLE/BUSY/NONSEQ/SEQ, HRESP_OKAY/ERROR, HSIZE_* constants
  - adapter state typedef enum {IDLE, ACCESS, ERR1, ERR2}
- Sub-module ahb_be_decode: combinational (size, addr offset) -> be, legal flag; parametrised by DATA_WIDTH.

Test Plan:
- 32-bit word write 0x0000_0010 data 0xA5A5_5A5A, ack after 3 cycles -> hready_o low 3 cycles; reg_be=4'hF; reg_wdata=0xA5A5_5A5A; hresp=0.
- Byte read at 0x13, reg_rdata=0x1122_3344, immediate ack -> reg_be=4'b1000; zero wait; hrdata=0x1122_3344.
- Halfword at 0x11, ERR_ON_UNALIGNED=1 -> reg_req never asserts; ERR1 (ready 0, resp 1) then ERR2 (ready 1, resp 1).
- Write with reg_ack+reg_err -> one cycle hready_o=0/hresp=1, then hready_o=1/hresp=1; following NONSEQ during ERR2 captured and completes OKAY.
- TIMEOUT_CYCLES=4, no ack -> reg_req high 4 cycles, then ERROR pair. Repeat with ack on cycle 4 -> OKAY.
- DATA_WIDTH=64: hsize=3 at 0x8 -> be=8'hFF. hsize=4 -> ERROR. Mid-ACCESS hresetn pulse -> reg_req=0, hready_o=1 immediately.

Source files
------------

// File: rtl/ahb_pkg.sv
// ahb_pkg: AHB-Lite encodings and adapter state type shared by the slave bridge.
package ahb_pkg;
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;
  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;
  localparam logic [2:0] HSIZE_BYTE  = 3'd0;
  localparam logic [2:0] HSIZE_HALF  = 3'd1;
  localparam logic [2:0] HSIZE_WORD  = 3'd2;
  localparam logic [2:0] HSIZE_DWORD = 3'd3;
  localparam logic [2:0] HSIZE_QWORD = 3'd4;
  typedef enum logic [1:0] {IDLE, ACCESS, ERR1, ERR2} adapter_state_e;
endpackage

// File: rtl/ahb_be_decode.sv
// ahb_be_decode: transfer size and address offset to byte enables plus legality flag.
module ahb_be_decode #(
  parameter int DATA_WIDTH = 32,
  parameter bit ERR_ON_UNALIGNED = 1'b1,
  localparam int NBYTES = DATA_WIDTH / 8,
  localparam int OFFW = $clog2(NBYTES)
) (
  input  logic [2:0]        size,
  input  logic [OFFW-1:0]   off,
  output logic [NBYTES-1:0] be,
  output logic              legal
);
  int nb;
  always_comb begin
    nb = 1 << size;
    legal = (int'(size) <= OFFW) && (((int'(off) & (nb - 1)) == 0) || !ERR_ON_UNALIGNED);
    for (int i = 0; i < NBYTES; i++) be[i] = (i >= int'(off)) && (i < int'(off) + nb);
  end
endmodule

// File: rtl/ahb_slave_adapter_ws.sv
// ahb_slave_adapter_ws: AHB-Lite slave to req/ack register bus with wait states,
// two-cycle ERROR response and a native-side watchdog.
module ahb_slave_adapter_ws import ahb_pkg::*; #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT_CYCLES = 256,
  parameter bit ERR_ON_UNALIGNED = 1'b1,
  localparam int NBYTES = DATA_WIDTH / 8,
  localparam int OFFW = $clog2(NBYTES)
) (
  input  logic                  hclk,
  input  logic                  hresetn,
  input  logic                  hsel,
  input  logic [ADDR_WIDTH-1:0] haddr,
  input  logic [1:0]            htrans,
  input  logic                  hwrite,
  input  logic [2:0]            hsize,
  input  logic [2:0]            hburst,
  input  logic [3:0]            hprot,
  input  logic [DATA_WIDTH-1:0] hwdata,
  input  logic                  hready_i,
  output logic                  hready_o,
  output logic                  hresp,
  output logic [DATA_WIDTH-1:0] hrdata,
  output logic                  reg_req,
  output logic [ADDR_WIDTH-1:0] reg_addr,
  output logic                  reg_we,
  output logic [NBYTES-1:0]     reg_be,
  output logic [DATA_WIDTH-1:0] reg_wdata,
  input  logic [DATA_WIDTH-1:0] reg_rdata,
  input  logic                  reg_ack,
  input  logic                  reg_err
);
  localparam int CW = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int TO_LAST = TIMEOUT_CYCLES > 0 ? TIMEOUT_CYCLES - 1 : 0;
  adapter_state_e state_q, state_d, nxt;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic we_q, we_d;
  logic [NBYTES-1:0] be_q, be_d, dec_be;
  logic [CW-1:0] cnt_q, cnt_d;
  logic dec_legal, cap, done, timeout, unused_ok;
  ahb_be_decode #(.DATA_WIDTH(DATA_WIDTH), .ERR_ON_UNALIGNED(ERR_ON_UNALIGNED)) u_dec (
    .size(hsize),
    .off(haddr[OFFW-1:0]),
    .be(dec_be),
    .legal(dec_legal)
  );
  always_comb unused_ok = ^{hburst, hprot, htrans[0]};
  // hready_o is low in ERR1 and in un-acked ACCESS, so gating capture with it
  // limits capture to IDLE, ERR2 and the completing ACCESS cycle.
  always_comb begin
    done = state_q == ACCESS && reg_ack && !reg_err;
    hready_o = state_q == IDLE || state_q == ERR2 || done;
    hresp = (state_q == ERR1 || state_q == ERR2) ? HRESP_ERROR : HRESP_OKAY;
    reg_req = state_q == ACCESS;
    reg_addr = addr_q;
    reg_we = we_q;
    reg_be = be_q;
    reg_wdata = reg_req ? hwdata : '0;
    hrdata = (reg_req && !we_q) ? reg_rdata : '0;
    cap = hsel && hready_i && htrans[1] && hready_o;
    timeout = TIMEOUT_CYCLES != 0 && cnt_q == CW'(TO_LAST);
    cnt_d = (reg_req && !reg_ack && TIMEOUT_CYCLES != 0) ? cnt_q + CW'(1) : '0;
    addr_d = cap ? haddr : addr_q;
    we_d = cap ? hwrite : we_q;
    be_d = cap ? dec_be : be_q;
    nxt = cap ? (dec_legal ? ACCESS : ERR1) : IDLE;
    state_d = state_q == ERR1 ? ERR2 :
              (state_q != ACCESS || done) ? nxt :
              (reg_ack || timeout) ? ERR1 : ACCESS;
  end
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state_q <= IDLE;
      addr_q <= '0;
      we_q <= 1'b0;
      be_q <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      we_q <= we_d;
      be_q <= be_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: tb/tb_ahb_slave_adapter_ws.sv
// tb_ahb_slave_adapter_ws: two adapters (32-bit strict, 64-bit lenient) driven by
// directed transfers; a monitor checks AHB and native sides against queued expectations.
module tb_ahb_slave_adapter_ws;
  typedef struct { int inst; logic resp; logic [63:0] rdata; int waits; } exp_t;
  typedef struct { int inst; logic [31:0] addr; logic we; logic [7:0] be; logic [63:0] wdata; } nexp_t;
  logic hclk, hresetn, hwrite;
  logic [1:0] hsel, htrans, ack, rerr, t_err, t_noack;
  logic [31:0] haddr;
  logic [2:0] hsize;
  logic [63:0] hwdata;
  logic [63:0] t_rdata [2];
  int t_delay [2];
  int wcnt [2];
  wire [1:0] hready, hresp, req, rwe;
  wire [31:0] hrd_a, wd_a, radr_a, radr_b;
  wire [63:0] hrd_b, wd_b;
  wire [3:0] be_a;
  wire [7:0] be_b;
  int tests = 0, fails = 0;
  exp_t q[$];
  nexp_t nq[$];
  exp_t me;
  nexp_t mn;
  logic [63:0] m_rd, m_wd;
  logic [31:0] m_ad;
  logic [7:0] m_be;
  logic [1:0] dp, busy, lr;
  int w [2];

  ahb_slave_adapter_ws #(.DATA_WIDTH(32), .TIMEOUT_CYCLES(4), .ERR_ON_UNALIGNED(1'b1)) u_a (
    .hclk(hclk), .hresetn(hresetn), .hsel(hsel[0]), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hburst(3'b000), .hprot(4'b0011), .hwdata(hwdata[31:0]),
    .hready_i(hready[0]), .hready_o(hready[0]), .hresp(hresp[0]), .hrdata(hrd_a),
    .reg_req(req[0]), .reg_addr(radr_a), .reg_we(rwe[0]), .reg_be(be_a), .reg_wdata(wd_a),
    .reg_rdata(t_rdata[0][31:0]), .reg_ack(ack[0]), .reg_err(rerr[0])
  );
  ahb_slave_adapter_ws #(.DATA_WIDTH(64), .TIMEOUT_CYCLES(8), .ERR_ON_UNALIGNED(1'b0)) u_b (
    .hclk(hclk), .hresetn(hresetn), .hsel(hsel[1]), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hburst(3'b001), .hprot(4'b0011), .hwdata(hwdata),
    .hready_i(hready[1]), .hready_o(hready[1]), .hresp(hresp[1]), .hrdata(hrd_b),
    .reg_req(req[1]), .reg_addr(radr_b), .reg_we(rwe[1]), .reg_be(be_b), .reg_wdata(wd_b),
    .reg_rdata(t_rdata[1]), .reg_ack(ack[1]), .reg_err(rerr[1])
  );

  initial begin
    hclk = 0;
    forever #5 hclk = ~hclk;
  end

  // Target model: ack after t_delay request cycles unless t_noack; ack never looks at hready_o.
  assign ack[0] = req[0] && wcnt[0] == t_delay[0] && !t_noack[0];
  assign ack[1] = req[1] && wcnt[1] == t_delay[1] && !t_noack[1];
  assign rerr = ack & t_err;
  always @(posedge hclk)
    for (int i = 0; i < 2; i++) wcnt[i] <= (req[i] && !ack[i]) ? wcnt[i] + 1 : 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tcfg(input int i, input int d, input logic e, input logic [63:0] rd, input logic na);
    t_delay[i] = d;
    t_err[i] = e;
    t_rdata[i] = rd;
    t_noack[i] = na;
  endtask

  task automatic exp_ahb(input int i, input logic r, input logic [63:0] rd, input int wt);
    q.push_back('{i, r, rd, wt});
  endtask

  task automatic exp_nat(input int i, input logic [31:0] a, input logic we, input logic [7:0] be, input logic [63:0] wd);
    nq.push_back('{i, a, we, be, wd});
  endtask

  task automatic addr_phase(input int i, input logic [31:0] a, input logic wr, input logic [2:0] s, input logic [63:0] wd);
    int n;
    hsel = 2'b01 << i;
    haddr = a;
    hwrite = wr;
    hsize = s;
    htrans = 2'b10;
    n = 0;
    do begin
      @(negedge hclk);
      n++;
    end while (!hready[i] && n < 50);
    if (!hready[i]) chk("addr_phase_timeout", 64'(hready[i]), 64'd1);
    @(posedge hclk);
    #1;
    hwdata = wd;
    hsel = 2'b00;
    htrans = 2'b00;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (q.size() != 0 && n < 60) begin
      @(negedge hclk);
      #1;
      n++;
    end
    if (q.size() != 0) begin
      chk("completion_timeout", 64'(q.size()), 64'd0);
      q.delete();
    end
    @(posedge hclk);
    #1;
  endtask

  // Monitor: pops an AHB expectation at each data-phase completion and a native
  // expectation at the first cycle of each native request.
  initial begin
    dp = 0;
    busy = 0;
    lr = 0;
    w[0] = 0;
    w[1] = 0;
    forever begin
      @(negedge hclk);
      for (int i = 0; i < 2; i++) begin
        if (!hresetn) begin
          dp[i] = 0;
          busy[i] = 0;
          w[i] = 0;
        end else begin
          if (dp[i]) begin
            if (!hready[i]) begin
              w[i]++;
              lr[i] = hresp[i];
            end else if (q.size() == 0) chk("unexpected_completion", 64'(i), 64'hFF);
            else begin
              me = q.pop_front();
              m_rd = (i == 1) ? hrd_b : {32'h0, hrd_a};
              chk("ahb_inst", 64'(i), 64'(me.inst));
              chk("hresp", 64'(hresp[i]), 64'(me.resp));
              chk("hrdata", m_rd, me.rdata);
              chk("wait_states", 64'(w[i]), 64'(me.waits));
              if (me.resp) chk("err1_hresp", 64'(lr[i]), 64'd1);
            end
          end
          if (hready[i]) begin
            dp[i] = hsel[i] && htrans[1];
            w[i] = 0;
            lr[i] = 0;
          end
          if (req[i] && !busy[i]) begin
            if (nq.size() == 0) chk("unexpected_reg_req", 64'(i), 64'hFF);
            else begin
              mn = nq.pop_front();
              m_ad = (i == 1) ? radr_b : radr_a;
              m_be = (i == 1) ? be_b : {4'h0, be_a};
              m_wd = (i == 1) ? wd_b : {32'h0, wd_a};
              chk("nat_inst", 64'(i), 64'(mn.inst));
              chk("reg_addr", 64'(m_ad), 64'(mn.addr));
              chk("reg_we", 64'(rwe[i]), 64'(mn.we));
              chk("reg_be", 64'(m_be), 64'(mn.be));
              chk("reg_wdata", m_wd, mn.wdata);
            end
          end
          busy[i] = req[i] && !ack[i];
        end
      end
    end
  end

  initial begin
    hresetn = 0;
    hsel = 0;
    haddr = 0;
    htrans = 0;
    hwrite = 0;
    hsize = 0;
    hwdata = 0;
    tcfg(0, 0, 0, 0, 0);
    tcfg(1, 0, 0, 0, 0);
    repeat (2) @(posedge hclk);
    #1;
    chk("rst_hready", 64'(hready), 64'h3);
    chk("rst_hresp", 64'(hresp), 64'h0);
    chk("rst_reg_req", 64'(req), 64'h0);
    chk("rst_reg_we", 64'(rwe), 64'h0);
    chk("rst_hrdata_a", 64'(hrd_a), 64'h0);
    chk("rst_hrdata_b", hrd_b, 64'h0);
    chk("rst_reg_be", {52'h0, be_b, be_a}, 64'h0);
    chk("rst_reg_addr", {radr_b, radr_a}, 64'h0);
    chk("rst_reg_wdata", wd_b | {32'h0, wd_a}, 64'h0);
    hresetn = 1;
    @(posedge hclk);
    #1;
    // word write, three wait states
    tcfg(0, 3, 0, 0, 0);
    exp_nat(0, 32'h10, 1, 8'h0F, 64'hA5A5_5A5A);
    exp_ahb(0, 0, 64'h0, 3);
    addr_phase(0, 32'h10, 1, 3'd2, 64'hA5A5_5A5A);
    wait_done();
    // byte read at lane 3, zero wait
    tcfg(0, 0, 0, 64'h1122_3344, 0);
    exp_nat(0, 32'h13, 0, 8'h08, 64'h0);
    exp_ahb(0, 0, 64'h1122_3344, 0);
    addr_phase(0, 32'h13, 0, 3'd0, 64'h0);
    wait_done();
    // unaligned halfword: no native request, ERROR pair
    exp_ahb(0, 1, 64'h0, 1);
    addr_phase(0, 32'h11, 0, 3'd1, 64'h0);
    wait_done();
    // target error then a read captured during ERR2
    tcfg(0, 1, 1, 0, 0);
    exp_nat(0, 32'h20, 1, 8'h0F, 64'h1357_9BDF);
    exp_ahb(0, 1, 64'h0, 3);
    exp_nat(0, 32'h24, 0, 8'h0F, 64'h0);
    exp_ahb(0, 0, 64'hCAFE_F00D, 0);
    addr_phase(0, 32'h20, 1, 3'd2, 64'h1357_9BDF);
    addr_phase(0, 32'h24, 0, 3'd2, 64'h0);
    tcfg(0, 0, 0, 64'hCAFE_F00D, 0);
    wait_done();
    // watchdog: four request cycles then ERROR
    tcfg(0, 0, 0, 0, 1);
    exp_nat(0, 32'h30, 1, 8'h0F, 64'h0BAD_C0DE);
    exp_ahb(0, 1, 64'h0, 5);
    addr_phase(0, 32'h30, 1, 3'd2, 64'h0BAD_C0DE);
    wait_done();
    // ack in the last allowed cycle completes OKAY
    tcfg(0, 3, 0, 64'h55AA_1234, 0);
    exp_nat(0, 32'h34, 0, 8'h0F, 64'h0);
    exp_ahb(0, 0, 64'h55AA_1234, 3);
    addr_phase(0, 32'h34, 0, 3'd2, 64'h0);
    wait_done();
    // 64-bit doubleword write
    tcfg(1, 0, 0, 0, 0);
    exp_nat(1, 32'h8, 1, 8'hFF, 64'h0123_4567_89AB_CDEF);
    exp_ahb(1, 0, 64'h0, 0);
    addr_phase(1, 32'h8, 1, 3'd3, 64'h0123_4567_89AB_CDEF);
    wait_done();
    // hsize wider than the bus
    exp_ahb(1, 1, 64'h0, 1);
    addr_phase(1, 32'h0, 0, 3'd4, 64'h0);
    wait_done();
    // lenient unaligned halfword and word with shifted enables
    tcfg(1, 2, 0, 64'hDEAD_BEEF_00C0_FFEE, 0);
    exp_nat(1, 32'hB, 0, 8'h18, 64'h0);
    exp_ahb(1, 0, 64'hDEAD_BEEF_00C0_FFEE, 2);
    addr_phase(1, 32'hB, 0, 3'd1, 64'h0);
    wait_done();
    tcfg(1, 0, 0, 0, 0);
    exp_nat(1, 32'h6, 1, 8'hC0, 64'h1111_2222_3333_4444);
    exp_ahb(1, 0, 64'h0, 0);
    addr_phase(1, 32'h6, 1, 3'd2, 64'h1111_2222_3333_4444);
    wait_done();
    // async reset in the middle of an ACCESS
    tcfg(1, 0, 0, 0, 1);
    exp_nat(1, 32'h40, 0, 8'hFF, 64'h0);
    addr_phase(1, 32'h40, 0, 3'd3, 64'h0);
    @(negedge hclk);
    @(negedge hclk);
    #2;
    hresetn = 0;
    #1;
    chk("midrst_reg_req", 64'(req[1]), 64'h0);
    chk("midrst_hready", 64'(hready[1]), 64'h1);
    chk("midrst_hresp", 64'(hresp[1]), 64'h0);
    @(posedge hclk);
    @(posedge hclk);
    #1;
    hresetn = 1;
    tcfg(1, 1, 0, 64'h8877_6655_4433_2211, 0);
    exp_nat(1, 32'h10, 0, 8'h0F, 64'h0);
    exp_ahb(1, 0, 64'h8877_6655_4433_2211, 1);
    addr_phase(1, 32'h10, 0, 3'd2, 64'h0);
    wait_done();
    repeat (2) @(posedge hclk);
    chk("ahb_queue_drained", 64'(q.size()), 64'h0);
    chk("nat_queue_drained", 64'(nq.size()), 64'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
